// File: rtl/apb_cpu_if_initiator_pkg.sv
// Shared types and constants for the APB to CPU-interface initiator.
package cpu_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CPU_ADDR_W = 30;
    localparam int CPU_DATA_W = 32;

    localparam logic [CPU_DATA_W-1:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_cpu_if_initiator_if.sv
// APB3 bus bundle; the initiator block takes the slave modport.
interface apb_cpu_if_initiator_if;
    import cpu_if_pkg::*;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [31:0]           paddr;
    logic [CPU_DATA_W-1:0] pwdata;
    logic [CPU_DATA_W-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_cpu_if_initiator_timer.sv
// Wait-state timer: cleared with the request pulse, counts while enabled, holds at expiry.
module cpu_if_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic l_clk,
    input  logic areset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Saturating at LAST keeps the counter from wrapping while the FSM stays in WAIT.
    always_ff @(posedge l_clk) begin
        if (areset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/apb_cpu_if_initiator.sv
// APB3 slave turning each transfer into one CPU-interface read/write pulse, with
// timeout recovery and accounting of completions that belong to timed-out requests.
module apb_cpu_if_initiator
    import cpu_if_pkg::*;
#(
    parameter int                    TIMEOUT_CYCLES = 256,
    parameter logic [CPU_DATA_W-1:0] ERR_RDATA      = DEFAULT_ERR_RDATA,
    parameter int                    STALE_W        = 4
) (
    input  logic                  l_clk,
    input  logic                  areset,
    apb_cpu_if_initiator_if.slave apb,
    output logic                  l_cpu_if_read,
    output logic                  l_cpu_if_write,
    output logic [CPU_ADDR_W-1:0] l_cpu_if_address,
    output logic [CPU_DATA_W-1:0] l_cpu_if_write_data,
    input  logic [CPU_DATA_W-1:0] l_cpu_if_read_data,
    input  logic                  l_cpu_if_access_complete,
    output logic                  timeout_pulse,
    output logic                  spurious_pulse,
    output logic [STALE_W-1:0]    stale_count
);

    localparam logic [STALE_W-1:0] STALE_MAX = '1;

    state_t state, next_state;

    logic access;
    logic start;
    logic misalign_err;
    logic done_ok;
    logic stale_dec;
    logic timeout_fire;
    logic spurious;
    logic timer_expire;

    logic                  cur_write;
    logic [CPU_DATA_W-1:0] rdata_q;
    logic                  err_q;
    logic [STALE_W-1:0]    stale_q;

    assign access = apb.psel & apb.penable;

    always_ff @(posedge l_clk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outside WAIT a completion either retires a stale request or is spurious.
    always_comb begin
        next_state   = state;
        start        = 1'b0;
        misalign_err = 1'b0;
        done_ok      = 1'b0;
        stale_dec    = 1'b0;
        timeout_fire = 1'b0;
        spurious     = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (state == RESP) begin
                    next_state = IDLE;
                end else if (access) begin
                    if (apb.paddr[1:0] == 2'b00) begin
                        start      = 1'b1;
                        next_state = WAIT;
                    end else begin
                        misalign_err = 1'b1;
                        next_state   = RESP;
                    end
                end
                if (l_cpu_if_access_complete) begin
                    if (stale_q != '0) begin
                        stale_dec = 1'b1;
                    end else begin
                        spurious = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (l_cpu_if_access_complete && (stale_q != '0)) begin
                    stale_dec = 1'b1;
                end
                if (l_cpu_if_access_complete && (stale_q == '0)) begin
                    done_ok    = 1'b1;
                    next_state = RESP;
                end else if (timer_expire) begin
                    timeout_fire = 1'b1;
                    next_state   = RESP;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    cpu_if_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .l_clk (l_clk),
        .areset(areset),
        .clear (start),
        .enable(state == WAIT),
        .expire(timer_expire)
    );

    // Address and write data only move on a real request so they stay stable between pulses.
    always_ff @(posedge l_clk) begin
        if (areset) begin
            l_cpu_if_read       <= 1'b0;
            l_cpu_if_write      <= 1'b0;
            l_cpu_if_address    <= '0;
            l_cpu_if_write_data <= '0;
            cur_write           <= 1'b0;
            rdata_q             <= '0;
            err_q               <= 1'b0;
            timeout_pulse       <= 1'b0;
            spurious_pulse      <= 1'b0;
        end else begin
            l_cpu_if_read  <= start & ~apb.pwrite;
            l_cpu_if_write <= start & apb.pwrite;
            timeout_pulse  <= timeout_fire;
            spurious_pulse <= spurious;
            if (start) begin
                l_cpu_if_address    <= apb.paddr[31:2];
                l_cpu_if_write_data <= apb.pwdata;
                cur_write           <= apb.pwrite;
            end
            if (misalign_err || timeout_fire) begin
                rdata_q <= ERR_RDATA;
                err_q   <= 1'b1;
            end else if (done_ok) begin
                rdata_q <= cur_write ? '0 : l_cpu_if_read_data;
                err_q   <= 1'b0;
            end
        end
    end

    // A stale completion landing in the timeout cycle cancels that cycle's increment.
    always_ff @(posedge l_clk) begin
        if (areset) begin
            stale_q <= '0;
        end else if (timeout_fire && !stale_dec) begin
            if (stale_q != STALE_MAX) begin
                stale_q <= stale_q + STALE_W'(1);
            end
        end else if (stale_dec && !timeout_fire) begin
            stale_q <= stale_q - STALE_W'(1);
        end
    end

    assign apb.pready  = (state == RESP);
    assign apb.prdata  = apb.pready ? rdata_q : '0;
    assign apb.pslverr = apb.pready & err_q;
    assign stale_count = stale_q;

endmodule

// File: tb/tb_apb_cpu_if_initiator.sv
// Scoreboard bench for apb_cpu_if_initiator with a short timeout so timeout paths run quickly.
module tb_apb_cpu_if_initiator;

    localparam int          TO      = 16;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
        logic        tmo;
    } exp_t;

    logic        l_clk = 1'b0;
    logic        areset;
    logic        l_cpu_if_read;
    logic        l_cpu_if_write;
    logic [29:0] l_cpu_if_address;
    logic [31:0] l_cpu_if_write_data;
    logic [31:0] l_cpu_if_read_data;
    logic        l_cpu_if_access_complete;
    logic        timeout_pulse;
    logic        spurious_pulse;
    logic [3:0]  stale_count;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   stale_m  = 0;
    exp_t sb[$];

    apb_cpu_if_initiator_if apb ();

    apb_cpu_if_initiator #(
        .TIMEOUT_CYCLES(TO),
        .ERR_RDATA     (ERR_VAL),
        .STALE_W       (4)
    ) dut (
        .l_clk                   (l_clk),
        .areset                  (areset),
        .apb                     (apb),
        .l_cpu_if_read           (l_cpu_if_read),
        .l_cpu_if_write          (l_cpu_if_write),
        .l_cpu_if_address        (l_cpu_if_address),
        .l_cpu_if_write_data     (l_cpu_if_write_data),
        .l_cpu_if_read_data      (l_cpu_if_read_data),
        .l_cpu_if_access_complete(l_cpu_if_access_complete),
        .timeout_pulse           (timeout_pulse),
        .spurious_pulse          (spurious_pulse),
        .stale_count             (stale_count)
    );

    always #5 l_clk = ~l_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got time %0t, need < 200000", $time);
        $fatal(1, "[TB] watchdog");
    end

    // One APB transfer; completions are driven in cycles c1/c2 counted from the access cycle.
    task automatic run_xfer(input string name, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int c1, input logic [31:0] d1,
                            input int c2, input logic [31:0] d2);
        exp_t e;
        exp_t got;
        bit   done;
        bit   leak;
        int   k;
        int   rd_pulses;
        int   wr_pulses;
        int   spur;
        bit   aligned;
        aligned   = (addr[1:0] == 2'b00);
        done      = 1'b0;
        leak      = 1'b0;
        rd_pulses = 0;
        wr_pulses = 0;
        spur      = 0;
        if (!aligned) begin
            e = '{1, ERR_VAL, 1'b1, 1'b0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                int c;
                c = (i == 0) ? c1 : c2;
                if (!done && c >= 1 && c <= TO) begin
                    if (stale_m > 0) begin
                        stale_m--;
                    end else begin
                        done = 1'b1;
                        e    = '{c + 1, wr ? 32'h0 : ((i == 0) ? d1 : d2), 1'b0, 1'b0};
                    end
                end
            end
            if (!done) begin
                e = '{TO + 1, ERR_VAL, 1'b1, 1'b1};
                if (stale_m < 15) stale_m++;
            end
        end
        sb.push_back(e);

        @(negedge l_clk);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = addr;
        apb.pwdata  = wdata;
        @(negedge l_clk);
        apb.penable = 1'b1;
        k = 0;
        forever begin
            @(negedge l_clk);
            k++;
            rd_pulses += int'(l_cpu_if_read);
            wr_pulses += int'(l_cpu_if_write);
            spur      += int'(spurious_pulse);
            if (k == 1 && aligned) begin
                n_checks++;
                if (l_cpu_if_address !== addr[31:2])
                    $display("[TB] FAIL %s address: got %h, need %h", name, l_cpu_if_address, addr[31:2]);
                else n_pass++;
                n_checks++;
                if (l_cpu_if_write_data !== wdata)
                    $display("[TB] FAIL %s write_data: got %h, need %h", name, l_cpu_if_write_data, wdata);
                else n_pass++;
            end
            if (apb.pready === 1'b1) begin
                got = sb.pop_front();
                n_checks++;
                if (k !== got.cyc)
                    $display("[TB] FAIL %s pready cycle: got T%0d, need T%0d", name, k, got.cyc);
                else n_pass++;
                n_checks++;
                if (apb.prdata !== got.data)
                    $display("[TB] FAIL %s prdata: got %h, need %h", name, apb.prdata, got.data);
                else n_pass++;
                n_checks++;
                if (apb.pslverr !== got.err)
                    $display("[TB] FAIL %s pslverr: got %b, need %b", name, apb.pslverr, got.err);
                else n_pass++;
                n_checks++;
                if (timeout_pulse !== got.tmo)
                    $display("[TB] FAIL %s timeout_pulse: got %b, need %b", name, timeout_pulse, got.tmo);
                else n_pass++;
                break;
            end
            if (apb.prdata !== 32'h0 || apb.pslverr !== 1'b0 || timeout_pulse !== 1'b0) leak = 1'b1;
            if (k > TO + 8) begin
                n_checks++;
                $display("[TB] FAIL %s pready wait: got none by T%0d, need T%0d", name, k, e.cyc);
                sb.delete();
                break;
            end
            l_cpu_if_access_complete = (k == c1) || (k == c2);
            l_cpu_if_read_data       = (k == c1) ? d1 : ((k == c2) ? d2 : 32'h0);
        end
        l_cpu_if_access_complete = 1'b0;
        l_cpu_if_read_data       = 32'h0;
        apb.psel                 = 1'b0;
        apb.penable              = 1'b0;

        n_checks++;
        if (rd_pulses !== ((aligned && !wr) ? 1 : 0))
            $display("[TB] FAIL %s read pulses: got %0d, need %0d", name, rd_pulses, (aligned && !wr) ? 1 : 0);
        else n_pass++;
        n_checks++;
        if (wr_pulses !== ((aligned && wr) ? 1 : 0))
            $display("[TB] FAIL %s write pulses: got %0d, need %0d", name, wr_pulses, (aligned && wr) ? 1 : 0);
        else n_pass++;
        n_checks++;
        if (leak || spur != 0)
            $display("[TB] FAIL %s idle outputs: got leak=%0b spurious=%0d, need 0/0", name, leak, spur);
        else n_pass++;
        n_checks++;
        if (int'(stale_count) !== stale_m)
            $display("[TB] FAIL %s stale_count: got %0d, need %0d", name, stale_count, stale_m);
        else n_pass++;
    endtask

    task automatic check_quiet(input string name);
        n_checks++;
        if ({apb.pready, apb.pslverr, apb.prdata, l_cpu_if_read, l_cpu_if_write,
             timeout_pulse, spurious_pulse, stale_count} !== '0)
            $display("[TB] FAIL %s outputs: got rdy=%b err=%b rd=%h r=%b w=%b to=%b sp=%b st=%0d, need all 0",
                     name, apb.pready, apb.pslverr, apb.prdata, l_cpu_if_read, l_cpu_if_write,
                     timeout_pulse, spurious_pulse, stale_count);
        else n_pass++;
    endtask

    task automatic test_reset();
        areset                   = 1'b1;
        apb.psel                 = 1'b0;
        apb.penable              = 1'b0;
        apb.pwrite               = 1'b0;
        apb.paddr                = 32'h0;
        apb.pwdata               = 32'h0;
        l_cpu_if_read_data       = 32'h0;
        l_cpu_if_access_complete = 1'b0;
        repeat (3) @(negedge l_clk);
        check_quiet("reset");
        n_checks++;
        if ({l_cpu_if_address, l_cpu_if_write_data} !== '0)
            $display("[TB] FAIL reset cpu_if bus: got %h/%h, need 0/0", l_cpu_if_address, l_cpu_if_write_data);
        else n_pass++;
        areset = 1'b0;
    endtask

    task automatic test_write();
        run_xfer("write", 1'b1, 32'h0000_0010, 32'hA5A5_0001, 7, 32'h0, -1, 32'h0);
    endtask

    task automatic test_read_same_cycle();
        run_xfer("read_t1", 1'b0, 32'h0000_0020, 32'h0, 1, 32'h1234_5678, -1, 32'h0);
    endtask

    task automatic test_timeout();
        run_xfer("timeout", 1'b0, 32'h0000_0024, 32'h0, -1, 32'h0, -1, 32'h0);
    endtask

    task automatic test_stale();
        run_xfer("stale", 1'b0, 32'h0000_0028, 32'h0, 3, 32'h0BAD_0BAD, 5, 32'hCAFE_0002);
    endtask

    task automatic test_misalign();
        run_xfer("misalign", 1'b1, 32'h0000_0013, 32'h1111_2222, -1, 32'h0, -1, 32'h0);
    endtask

    task automatic test_terminal();
        run_xfer("terminal", 1'b0, 32'h0000_0030, 32'h0, TO, 32'h5555_AAAA, -1, 32'h0);
    endtask

    task automatic test_spurious(input string name);
        @(negedge l_clk);
        l_cpu_if_access_complete = 1'b1;
        l_cpu_if_read_data       = 32'h7777_7777;
        @(negedge l_clk);
        l_cpu_if_access_complete = 1'b0;
        n_checks++;
        if (spurious_pulse !== 1'b1 || apb.pready !== 1'b0 || stale_count !== 4'd0)
            $display("[TB] FAIL %s: got sp=%b rdy=%b st=%0d, need 1/0/0", name, spurious_pulse, apb.pready, stale_count);
        else n_pass++;
        @(negedge l_clk);
        n_checks++;
        if (spurious_pulse !== 1'b0)
            $display("[TB] FAIL %s width: got %b, need 0", name, spurious_pulse);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'h0000_0100 + 32'(i * 4);
            d = $urandom;
            run_xfer("b2b", i[0], a, d, 2 + i, d ^ 32'hFFFF_0000, -1, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        test_timeout();
        @(negedge l_clk);
        apb.psel   = 1'b1;
        apb.pwrite = 1'b0;
        apb.paddr  = 32'h0000_0040;
        @(negedge l_clk);
        apb.penable = 1'b1;
        repeat (3) @(negedge l_clk);
        areset = 1'b1;
        @(negedge l_clk);
        check_quiet("reset_mid");
        areset      = 1'b0;
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        stale_m     = 0;
        test_spurious("spurious_after_reset");
        run_xfer("after_reset", 1'b0, 32'h0000_0044, 32'h0, 2, 32'h0A0B_0C0D, -1, 32'h0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_same_cycle();
        test_timeout();
        test_stale();
        test_misalign();
        test_spurious("spurious");
        test_terminal();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge l_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
